pstruct_array_arbiter: RTL and testbench
========================================

# pstruct_array_arbiter

Round-robin arbiter and sequencer that shares a small packed-struct register array (DEPTH entries of WIDTH bits) among NREQ requesters. Each access is a single read or write to one indexed entry. A one-hot state vector is exported for trace and SAIF activity capture. The block sits between requester logic and the array storage, which it owns. It also sequences a bulk-clear operation and flags out-of-range indices.

## Interface
- NREQ, 4, number of requesters (≥2)
- DEPTH, 5, number of array entries
- WIDTH, 33, bits per entry (one packed-struct field)
- IDX_W, 3, index width; must satisfy 2**IDX_W ≥ DEPTH
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester access request, level
- we  input  NREQ  per-requester write enable (0 = read)
- idx  input  NREQ×IDX_W  per-requester entry index, packed array
- wdata  input  NREQ×WIDTH  per-requester write data, packed array
- gnt  output  NREQ  one-hot grant, registered
- rvalid  output  1  read data valid, one-cycle pulse
- rdata  output  WIDTH  read data, held until next read
- rid  output  $clog2(NREQ)  requester that owns rdata
- err  output  1  out-of-range index pulse
- clr_start  input  1  request bulk clear of all entries
- clr_busy  output  1  clear in progress
- state  output  5  one-hot FSM state: bit0 IDLE, bit1 SERVE, bit2 RESP, bit3 CLEAR, bit4 ERR

## Operation
- Reset (async, any time): state=IDLE (5'b00001); gnt=0, rvalid=0, err=0, clr_busy=0; rdata=0, rid=0; RR pointer=0; all entries=0. Any in-flight access is abandoned.
- IDLE:
  - clr_start=1 → CLEAR, clear counter=0. clr_start wins over simultaneous req.
  - Otherwise, any req → arbitrate.
    - Winner = first set req bit searching upward from the pointer, wrapping at NREQ.
    - Capture the winner's we/idx/wdata, set gnt to the winner's one-hot, set pointer=(winner+1) mod NREQ.
    - idx<DEPTH → SERVE; idx≥DEPTH → ERR.
- SERVE: gnt high for exactly this cycle.
  - Write: entry[idx]<=wdata at the closing edge → IDLE.
  - Read: rdata<=entry[idx], rid<=winner → RESP.
- RESP: rvalid=1 for one cycle → IDLE.
- ERR: gnt high, err=1 for one cycle; no array access; pointer still advances → IDLE.
- CLEAR: clr_busy=1.
  - entry[counter]<=0 each cycle.
  - Counter reaches DEPTH-1 → IDLE.
  - req and clr_start are ignored (not queued).
- clr_start outside IDLE is dropped.
- A req dropped before arbitration is never granted. After gnt, the requester must deassert req in the following cycle or it re-arbitrates as a new access.
- Entries not being written hold their value.

## Timing
- Arbitration edge E0 in IDLE; gnt valid E0→E1.
- Write: entry updated at E1; visible to a read arbitrated at or after E1.
- Read: rdata/rid registered at E1; rvalid E1→E2; next arbitration no earlier than E2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Clear: DEPTH cycles of CLEAR, then IDLE.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package pstruct_arb_pkg holds:
  - entry_t: packed struct with a single logic [WIDTH-1:0] field.
  - state_e: one-hot enum, values as above.
  - Default DEPTH/WIDTH/NREQ constants.
- Storage: entry_t [DEPTH-1:0] packed array.
- Sub-module rr_arbiter (parameter NREQ): takes req and pointer, returns one-hot winner and winner index; purely combinational. The top module owns the pointer register and the FSM.

## Test plan
- Reset: hold rst_n=0 mid-read → state=5'b00001, gnt=0, rvalid=0, all entries 0; first read after release returns 0.
- Write then read:
  - req0 write idx=2, wdata=33'h1_2345_6789 → gnt=4'b0001 one cycle, entry2 updated.
  - req0 read idx=2 → rvalid one cycle later, rdata=33'h1_2345_6789, rid=0.
- Round-robin fairness: req=4'b1111 held continuously → grant order 0,1,2,3,0; pointer wraps from 3 to 0.
- Out-of-range index: req2 idx=5 → state ERR, err=1 one cycle, gnt=4'b0100, no entry changes, next grant goes to req3.
- Clear collision:
  - clr_start and req1 in the same IDLE cycle → CLEAR for 5 cycles with clr_busy=1; req1 is not granted until IDLE.
  - All 5 entries read back 0.
- Back-to-back access: req3 write idx=4 then req0 read idx=4 → read returns the new data; state sequence IDLE,SERVE,IDLE,SERVE,RESP,IDLE.

Source files
------------

// File: rtl/pstruct_arb_pkg.sv
// Shared types and default sizing for the packed-struct array arbiter.
// entry_t wraps one array entry; state_e is the one-hot sequencer state.
package pstruct_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DEPTH = 5;
    localparam int DEF_WIDTH = 33;
    localparam int DEF_IDX_W = 3;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

    // One-hot so the state register can be exported directly for trace capture.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SERVE = 5'b00010,
        S_RESP  = 5'b00100,
        S_CLEAR = 5'b01000,
        S_ERR   = 5'b10000
    } state_e;

endpackage

// File: rtl/pstruct_array_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// The caller owns the pointer register and decides when to advance it.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_oh,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);

    localparam int PTR_W = $clog2(NREQ);

    int cand;

    // NOTE: every output gets a default before the search loop, so no latch is inferred.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!any && req[cand]) begin
                any          = 1'b1;
                win_idx      = PTR_W'(cand);
                win_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pstruct_array_arbiter.sv
// Round-robin arbiter/sequencer owning a small packed-struct register array:
// single read or write per grant, bulk clear, and out-of-range index flagging.
module pstruct_array_arbiter
    import pstruct_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ-1:0]                  we,
    input  logic [NREQ-1:0][IDX_W-1:0]       idx,
    input  logic [NREQ-1:0][WIDTH-1:0]       wdata,
    output logic [NREQ-1:0]                  gnt,
    output logic                             rvalid,
    output logic [WIDTH-1:0]                 rdata,
    output logic [$clog2(NREQ)-1:0]          rid,
    output logic                             err,
    input  logic                             clr_start,
    output logic                             clr_busy,
    output logic [4:0]                       state
);

    localparam int RID_W = $clog2(NREQ);
    localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [RID_W-1:0] LAST_REQ = RID_W'(NREQ - 1);

    state_e                 state_q, state_d;
    entry_t [DEPTH-1:0]     mem_q;
    logic   [RID_W-1:0]     ptr_q;
    logic   [NREQ-1:0]      gnt_q;
    logic   [WIDTH-1:0]     rdata_q;
    logic   [RID_W-1:0]     rid_q;
    logic                   cur_we;
    logic   [IDX_W-1:0]     cur_idx;
    logic   [WIDTH-1:0]     cur_wdata;
    logic   [RID_W-1:0]     cur_id;
    logic   [IDX_W-1:0]     clr_cnt;

    logic   [NREQ-1:0]      win_oh;
    logic   [RID_W-1:0]     win_idx;
    logic                   req_any;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (req_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                end else if (req_any) begin
                    state_d = ({1'b0, idx[win_idx]} < DEPTH_X) ? S_SERVE : S_ERR;
                end
            end
            S_SERVE: state_d = cur_we ? S_IDLE : S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            S_CLEAR: state_d = (clr_cnt == LAST_IDX) ? S_IDLE : S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the array is reset with everything else because a reset must leave all entries zero;
    // sequential state below uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            rdata_q   <= '0;
            rid_q     <= '0;
            cur_we    <= 1'b0;
            cur_idx   <= '0;
            cur_wdata <= '0;
            cur_id    <= '0;
            clr_cnt   <= '0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (clr_start) begin
                        clr_cnt <= '0;
                    end else if (req_any) begin
                        gnt_q     <= win_oh;
                        ptr_q     <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                        cur_we    <= we[win_idx];
                        cur_idx   <= idx[win_idx];
                        cur_wdata <= wdata[win_idx];
                        cur_id    <= win_idx;
                    end
                end
                S_SERVE: begin
                    if (cur_we) begin
                        mem_q[cur_idx].data <= cur_wdata;
                    end else begin
                        rdata_q <= mem_q[cur_idx].data;
                        rid_q   <= cur_id;
                    end
                end
                S_CLEAR: begin
                    mem_q[clr_cnt] <= '0;
                    clr_cnt        <= clr_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are single flop bits of the one-hot state register.
    assign state    = state_q;
    assign rvalid   = state_q[2];
    assign clr_busy = state_q[3];
    assign err      = state_q[4];
    assign gnt      = gnt_q;
    assign rdata    = rdata_q;
    assign rid      = rid_q;

endmodule

// File: tb/tb_pstruct_array_arbiter.sv
// Directed and randomized checks of pstruct_array_arbiter against a
// transaction-level model (array contents + round-robin pointer).
module tb_pstruct_array_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 5;
    localparam int WIDTH = 33;
    localparam int IDX_W = 3;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_SERVE = 5'b00010;
    localparam logic [4:0] ST_RESP  = 5'b00100;
    localparam logic [4:0] ST_CLEAR = 5'b01000;
    localparam logic [4:0] ST_ERR   = 5'b10000;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             we;
    logic [NREQ-1:0][IDX_W-1:0]  idx;
    logic [NREQ-1:0][WIDTH-1:0]  wdata;
    logic [NREQ-1:0]             gnt;
    logic                        rvalid;
    logic [WIDTH-1:0]            rdata;
    logic [1:0]                  rid;
    logic                        err;
    logic                        clr_start;
    logic                        clr_busy;
    logic [4:0]                  state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_ptr;

    pstruct_array_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .IDX_W(IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .idx       (idx),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rid       (rid),
        .err       (err),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ptr = 0;
    endtask

    // One complete access from IDLE; expectations come from the model only.
    task automatic access(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] wev,
                          input logic [NREQ-1:0][IDX_W-1:0] ix,
                          input logic [NREQ-1:0][WIDTH-1:0] wd,
                          input bit hold, input bit clr_mid);
        int w;
        int c;
        int ti;
        logic [NREQ-1:0] oh;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (w < 0 && rq[c]) w = c;
        end
        oh    = '0;
        oh[w] = 1'b1;
        m_ptr = (w + 1) % NREQ;
        ti    = int'(ix[w]);

        check("pre_idle", 64'(state), 64'(ST_IDLE));
        req = rq; we = wev; idx = ix; wdata = wd;
        step();
        check("arb_gnt", 64'(gnt), 64'(oh));
        check("arb_rvalid", 64'(rvalid), 64'd0);
        if (ti >= DEPTH) begin
            check("arb_state_err", 64'(state), 64'(ST_ERR));
            check("arb_err", 64'(err), 64'd1);
        end else begin
            check("arb_state_serve", 64'(state), 64'(ST_SERVE));
            check("arb_err", 64'(err), 64'd0);
        end
        if (!hold) req = '0;
        if (clr_mid) clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("post_gnt", 64'(gnt), 64'd0);
        check("post_err", 64'(err), 64'd0);
        if (ti >= DEPTH || wev[w]) begin
            if (ti < DEPTH) m_mem[ti] = wd[w];
            check("post_state_idle", 64'(state), 64'(ST_IDLE));
            check("post_rvalid", 64'(rvalid), 64'd0);
        end else begin
            check("resp_state", 64'(state), 64'(ST_RESP));
            check("resp_rvalid", 64'(rvalid), 64'd1);
            check("resp_rdata", 64'(rdata), 64'(m_mem[ti]));
            check("resp_rid", 64'(rid), 64'(w));
            step();
            check("end_state_idle", 64'(state), 64'(ST_IDLE));
            check("end_rvalid", 64'(rvalid), 64'd0);
            check("end_rdata_held", 64'(rdata), 64'(m_mem[ti]));
        end
    endtask

    task automatic single(input int id, input bit w_en, input int ix_v,
                          input logic [WIDTH-1:0] d, input bit hold, input bit clr_mid);
        logic [NREQ-1:0]            rq;
        logic [NREQ-1:0]            wev;
        logic [NREQ-1:0][IDX_W-1:0] ix;
        logic [NREQ-1:0][WIDTH-1:0] wd;
        rq = '0; wev = '0; ix = '0; wd = '0;
        rq[id]  = 1'b1;
        wev[id] = w_en;
        ix[id]  = IDX_W'(ix_v);
        wd[id]  = d;
        access(rq, wev, ix, wd, hold, clr_mid);
    endtask

    initial begin
        logic [NREQ-1:0]            rq;
        logic [NREQ-1:0]            wev;
        logic [NREQ-1:0][IDX_W-1:0] ix;
        logic [NREQ-1:0][WIDTH-1:0] wd;

        rst_n = 1'b0; req = '0; we = '0; idx = '0; wdata = '0; clr_start = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_state", 64'(state), 64'(ST_IDLE));
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_clr_busy", 64'(clr_busy), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rid", 64'(rid), 64'd0);
        rst_n = 1'b1;
        step();

        // Reset asserted while a read sits in RESP.
        single(1, 1'b1, 2, 33'h0_dead_beef, 1'b0, 1'b0);
        req = 4'b0001; we = 4'b0000; idx = '0; idx[0] = 3'd2;
        step();
        check("mid_serve", 64'(state), 64'(ST_SERVE));
        req = '0;
        step();
        check("mid_resp_rvalid", 64'(rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", 64'(state), 64'(ST_IDLE));
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        single(3, 1'b0, 2, '0, 1'b0, 1'b0);

        // Held all-request traffic: grants 0,1,2,3,0 with the pointer wrapping.
        rq = 4'b1111; wev = '0; wd = '0;
        ix[0] = 3'd1; ix[1] = 3'd3; ix[2] = 3'd4; ix[3] = 3'd0;
        for (int i = 0; i < 5; i++) access(rq, wev, ix, wd, (i < 4), 1'b0);

        // Write then read back on requester 0.
        single(0, 1'b1, 2, 33'h1_2345_6789, 1'b0, 1'b0);
        single(0, 1'b0, 2, '0, 1'b0, 1'b0);

        // Out-of-range index, then the pointer should favour requester 3.
        single(2, 1'b1, 5, 33'h1_ffff_ffff, 1'b0, 1'b0);
        rq = 4'b1001; wev = '0; wd = '0; ix = '0; ix[0] = 3'd2; ix[3] = 3'd2;
        access(rq, wev, ix, wd, 1'b0, 1'b0);

        // Back-to-back write/read; a clr_start pulse during SERVE must be dropped.
        single(3, 1'b1, 4, 33'h0_cafe_f00d, 1'b0, 1'b1);
        single(0, 1'b0, 4, '0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rq = 4'($urandom_range(1, 15));
            wev = 4'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                ix[k] = 3'($urandom_range(0, 7));
                wd[k] = {1'($urandom), 32'($urandom)};
            end
            access(rq, wev, ix, wd, 1'b0, 1'b0);
        end

        // clr_start collides with req1: clear wins, req1 waits until IDLE.
        clr_start = 1'b1; req = 4'b0010; we = '0; idx = '0;
        step();
        clr_start = 1'b0;
        check("clr_state_0", 64'(state), 64'(ST_CLEAR));
        check("clr_busy_0", 64'(clr_busy), 64'd1);
        check("clr_gnt_0", 64'(gnt), 64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check("clr_state", 64'(state), 64'(ST_CLEAR));
            check("clr_busy", 64'(clr_busy), 64'd1);
            check("clr_gnt", 64'(gnt), 64'd0);
        end
        step();
        check("clr_done_state", 64'(state), 64'(ST_IDLE));
        check("clr_done_busy", 64'(clr_busy), 64'd0);
        check("clr_done_gnt", 64'(gnt), 64'd0);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        single(1, 1'b0, 0, '0, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) single(i % NREQ, 1'b0, i, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
